video_timing_gen: RTL and testbench

- Parametrised raster timing generator: the successor to the fixed ZX48/ZX128/Pentagon counter logic inside the video controller.
- Produces the following from a single pixel-rate clock enable:
  - horizontal and vertical counters
  - blanking and sync
  - border flag
  - CPU frame interrupt
  - flash phase
- Runtime-selectable machine profile; a profile change is deferred to the frame boundary so the display never sees a torn frame.
- Feeds the fetch/shift pipeline, the video mixer and the CPU interrupt input.

---
 rtl/video_timing_gen.sv | 148 ++++++++++++++
 tb/tb_video_timing_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, blank/sync, border, frame interrupt and flash
// phase for selectable Pentagon / ZX48 / ZX128 profiles, switched only at frame wrap.
package vtg_pkg;
  localparam int unsigned PW = 12;

  typedef struct packed {
    logic [PW-1:0] hmax, vmax;
    logic [PW-1:0] hbl_on, hbl_off, hs_on, hs_off;
    logic [PW-1:0] vbl_on, vbl_off, vs_on, vs_off;
    logic [PW-1:0] int_v, int_h;
  } prof_t;

  localparam prof_t PROF_PENT = '{hmax: 12'd447, vmax: 12'd319,
    hbl_on: 12'd312, hbl_off: 12'd420, hs_on: 12'd338, hs_off: 12'd370,
    vbl_on: 12'd236, vbl_off: 12'd272, vs_on: 12'd248, vs_off: 12'd256,
    int_v: 12'd239, int_h: 12'd324};
  localparam prof_t PROF_ZX48 = '{hmax: 12'd447, vmax: 12'd311,
    hbl_on: 12'd300, hbl_off: 12'd428, hs_on: 12'd336, hs_off: 12'd368,
    vbl_on: 12'd236, vbl_off: 12'd264, vs_on: 12'd240, vs_off: 12'd244,
    int_v: 12'd248, int_h: 12'd2};
  localparam prof_t PROF_ZX128 = '{hmax: 12'd455, vmax: 12'd310,
    hbl_on: 12'd312, hbl_off: 12'd424, hs_on: 12'd340, hs_off: 12'd372,
    vbl_on: 12'd236, vbl_off: 12'd264, vs_on: 12'd240, vs_off: 12'd244,
    int_v: 12'd248, int_h: 12'd6};
endpackage

module video_timing_gen #(
  parameter int unsigned HBITS      = 9,
  parameter int unsigned VBITS      = 9,
  parameter int unsigned INT_LEN    = 32,
  parameter int unsigned FLASH_BITS = 5,
  parameter int unsigned ACT_W      = 256,
  parameter int unsigned ACT_H      = 192,
  parameter vtg_pkg::prof_t P_PENT  = vtg_pkg::PROF_PENT,
  parameter vtg_pkg::prof_t P_ZX48  = vtg_pkg::PROF_ZX48,
  parameter vtg_pkg::prof_t P_ZX128 = vtg_pkg::PROF_ZX128
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [1:0]       mode,
  input  logic             int_en,
  output logic [HBITS-1:0] hc,
  output logic [VBITS-1:0] vc,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             border,
  output logic             nINT,
  output logic             flash,
  output logic             frame_start,
  output logic [1:0]       mode_act
);
  import vtg_pkg::*;

  localparam int unsigned ICW = 6;

  logic [HBITS-1:0]      r_hc;
  logic [VBITS-1:0]      r_vc;
  logic                  r_hblank, r_vblank, r_hsync, r_vsync;
  logic                  r_nint, r_frame_start;
  logic [ICW-1:0]        r_int_cnt;
  logic [FLASH_BITS-1:0] r_flash_cnt;
  logic [1:0]            r_mode_act;

  prof_t                 w_p;
  logic [PW-1:0]         w_hc_x, w_vc_x;
  logic                  w_hend, w_vend, w_wrap, w_int_hit;

  // Active profile lookup; reserved code 3 behaves as ZX48.
  always_comb begin
    w_p = P_ZX48;
    case (r_mode_act)
      2'd0:    w_p = P_PENT;
      2'd2:    w_p = P_ZX128;
      default: w_p = P_ZX48;
    endcase
  end

  assign w_hc_x    = PW'(r_hc);
  assign w_vc_x    = PW'(r_vc);
  assign w_hend    = (w_hc_x == w_p.hmax);
  assign w_vend    = (w_vc_x == w_p.vmax);
  assign w_wrap    = w_hend & w_vend;
  assign w_int_hit = int_en & (w_vc_x == w_p.int_v) & (w_hc_x == w_p.int_h);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_nint        <= 1'b1;
      r_int_cnt     <= '0;
      r_flash_cnt   <= '0;
      r_frame_start <= 1'b0;
      r_mode_act    <= mode;
    end else begin
      r_frame_start <= ce_pix & w_wrap;
      if (ce_pix) begin
        r_hc <= w_hend ? '0 : r_hc + HBITS'(1);
        if (w_hend) r_vc <= w_vend ? '0 : r_vc + VBITS'(1);
        if (w_wrap) begin
          r_flash_cnt <= r_flash_cnt + FLASH_BITS'(1);
          r_mode_act  <= mode;
        end

        // On/off compares are against the pre-increment count; "on" has priority.
        if (w_hc_x == w_p.hbl_on)       r_hblank <= 1'b1;
        else if (w_hc_x == w_p.hbl_off) r_hblank <= 1'b0;
        if (w_hc_x == w_p.hs_on)        r_hsync  <= 1'b1;
        else if (w_hc_x == w_p.hs_off)  r_hsync  <= 1'b0;

        if (w_hc_x == w_p.hs_on) begin
          if (w_vc_x == w_p.vbl_on)       r_vblank <= 1'b1;
          else if (w_vc_x == w_p.vbl_off) r_vblank <= 1'b0;
          if (w_vc_x == w_p.vs_on)        r_vsync  <= 1'b1;
          else if (w_vc_x == w_p.vs_off)  r_vsync  <= 1'b0;
        end

        // Interrupt pulse runs to completion and cannot retrigger while low.
        if (!r_nint) begin
          if (r_int_cnt == '0) r_nint    <= 1'b1;
          else                 r_int_cnt <= r_int_cnt - ICW'(1);
        end else if (w_int_hit) begin
          r_nint    <= 1'b0;
          r_int_cnt <= ICW'(INT_LEN - 1);
        end
      end
    end
  end

  assign hc          = r_hc;
  assign vc          = r_vc;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign nINT        = r_nint;
  assign flash       = r_flash_cnt[FLASH_BITS-1];
  assign frame_start = r_frame_start;
  assign mode_act    = r_mode_act;
  assign border      = (r_vc >= VBITS'(ACT_H)) | (r_hc >= HBITS'(ACT_W));

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: expected edge events (tagged with ce_pix tick count) and
// snapshot values are queued by the stimulus and checked by an independent monitor.
module tb_video_timing_gen;
  localparam int K_FS = 0, K_INT = 1, K_VS = 2, K_VB = 3, K_FL = 4, K_HB = 5, K_HS = 6;
  localparam int NK = 7;
  localparam int S_HC = 0, S_VC = 1, S_HBL = 2, S_VBL = 3, S_HS = 4, S_VS = 5,
                 S_BRD = 6, S_NINT = 7, S_FL = 8, S_FS = 9, S_MODE = 10;

  // Shrunk ZX128 profile so whole frames fit in a short run: 20 x 12 = 240 ticks.
  localparam vtg_pkg::prof_t MINI = '{hmax: 12'd19, vmax: 12'd11,
    hbl_on: 12'd12, hbl_off: 12'd17, hs_on: 12'd14, hs_off: 12'd16,
    vbl_on: 12'd8, vbl_off: 12'd10, vs_on: 12'd9, vs_off: 12'd10,
    int_v: 12'd2, int_h: 12'd3};

  typedef struct {
    int    sig;
    int    val;
    string nm;
  } snap_t;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ce_pix  = 1'b0;
  logic [1:0] mode    = 2'd1;
  logic       int_en  = 1'b1;
  logic [8:0] hc, vc;
  logic       hblank, vblank, hsync, vsync, border, nINT, flash, frame_start;
  logic [1:0] mode_act;

  int    ticks = 0;
  int    checks = 0, failures = 0;
  bit    mon_h = 1'b0, done = 1'b0;
  int    q_ev [NK][$];
  snap_t snap_q[$];
  snap_t cur;
  logic  p_fs = 1'b0, p_int = 1'b1, p_vs = 1'b0, p_vb = 1'b1, p_fl = 1'b0;
  logic  p_hb = 1'b1, p_hs = 1'b0;
  int    b;

  video_timing_gen #(.P_ZX128(MINI)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .mode(mode), .int_en(int_en),
    .hc(hc), .vc(vc), .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .border(border), .nINT(nINT), .flash(flash), .frame_start(frame_start),
    .mode_act(mode_act)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (reset)       ticks <= 0;
    else if (ce_pix) ticks <= ticks + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int sig_val(int s);
    int v;
    case (s)
      S_HC:    v = int'(hc);
      S_VC:    v = int'(vc);
      S_HBL:   v = int'(hblank);
      S_VBL:   v = int'(vblank);
      S_HS:    v = int'(hsync);
      S_VS:    v = int'(vsync);
      S_BRD:   v = int'(border);
      S_NINT:  v = int'(nINT);
      S_FL:    v = int'(flash);
      S_FS:    v = int'(frame_start);
      default: v = int'(mode_act);
    endcase
    return v;
  endfunction

  task automatic compare(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic ev(int k, int v, string nm);
    int e;
    checks++;
    if (q_ev[k].size() == 0) begin
      failures++;
      $display("FAIL %s: unexpected edge at tick %0d to level %0d", nm, v / 2, v % 2);
    end else begin
      e = q_ev[k].pop_front();
      if (e != v) begin
        failures++;
        $display("FAIL %s: got tick %0d level %0d expected tick %0d level %0d",
                 nm, v / 2, v % 2, e / 2, e % 2);
      end
    end
  endtask

  // Monitor: drains snapshot requests and matches observed edges against the queues.
  always @(negedge clk_sys) begin
    while (snap_q.size() > 0) begin
      cur = snap_q.pop_front();
      compare(cur.nm, sig_val(cur.sig), cur.val);
    end
    if (!reset && ticks != 0) begin
      if (frame_start) begin
        ev(K_FS, ticks * 2 + 1, "frame_start");
        compare("frame_start_width", int'(p_fs), 0);
      end
      if (nINT  != p_int) ev(K_INT, ticks * 2 + int'(nINT),  "nINT_edge");
      if (vsync != p_vs)  ev(K_VS,  ticks * 2 + int'(vsync), "vsync_edge");
      if (vblank != p_vb) ev(K_VB,  ticks * 2 + int'(vblank), "vblank_edge");
      if (flash != p_fl)  ev(K_FL,  ticks * 2 + int'(flash), "flash_edge");
      if (mon_h && hblank != p_hb) ev(K_HB, ticks * 2 + int'(hblank), "hblank_edge");
      if (mon_h && hsync  != p_hs) ev(K_HS, ticks * 2 + int'(hsync),  "hsync_edge");
    end
    p_fs = frame_start; p_int = nINT; p_vs = vsync; p_vb = vblank;
    p_fl = flash; p_hb = hblank; p_hs = hsync;
    if (done) begin
      for (int k = 0; k < NK; k++) compare($sformatf("leftover_events_kind%0d", k),
                                           q_ev[k].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic push(int k, int t, int lvl);
    q_ev[k].push_back(t * 2 + lvl);
  endtask

  task automatic expect_v(int s, int v, string nm);
    snap_q.push_back('{s, v, nm});
  endtask

  task automatic sync_chk();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic do_reset(logic [1:0] m);
    mode   = m;
    ce_pix = 1'b0;
    reset  = 1'b1;
    @(posedge clk_sys);
    #1;
    reset  = 1'b0;
  endtask

  task automatic run_to(int target, int duty);
    int c;
    c = 0;
    while (ticks < target) begin
      ce_pix = (c % duty == 0);
      c++;
      @(posedge clk_sys);
      #1;
    end
    ce_pix = 1'b0;
  endtask

  initial begin
    // ZX48 reset values and first-line horizontal timing.
    do_reset(2'd1);
    expect_v(S_HC, 0, "rst_hc");     expect_v(S_VC, 0, "rst_vc");
    expect_v(S_HBL, 1, "rst_hblank"); expect_v(S_VBL, 1, "rst_vblank");
    expect_v(S_HS, 0, "rst_hsync");  expect_v(S_VS, 0, "rst_vsync");
    expect_v(S_NINT, 1, "rst_nint"); expect_v(S_FL, 0, "rst_flash");
    expect_v(S_FS, 0, "rst_fs");     expect_v(S_MODE, 1, "rst_mode_act");
    sync_chk();
    mon_h = 1'b1;
    push(K_HS, 337, 1); push(K_HS, 369, 0); push(K_HB, 429, 0);
    run_to(255, 1);
    expect_v(S_HC, 255, "zx48_hc255"); expect_v(S_BRD, 0, "zx48_border_in");
    sync_chk();
    run_to(256, 1);
    expect_v(S_BRD, 1, "zx48_border_hc256");
    sync_chk();
    run_to(447, 1);
    expect_v(S_HC, 447, "zx48_hmax"); expect_v(S_VC, 0, "zx48_vc_line0");
    sync_chk();
    run_to(448, 1);
    expect_v(S_HC, 0, "zx48_hwrap"); expect_v(S_VC, 1, "zx48_vc_line1");
    expect_v(S_BRD, 0, "zx48_border_line1");
    sync_chk();
    run_to(460, 1);

    // Pentagon horizontal flags over two lines.
    do_reset(2'd0);
    push(K_HB, 421, 0); push(K_HB, 761, 1); push(K_HB, 869, 0);
    push(K_HS, 339, 1); push(K_HS, 371, 0); push(K_HS, 787, 1); push(K_HS, 819, 0);
    run_to(900, 1);
    expect_v(S_HC, 4, "pent_hc");   expect_v(S_VC, 2, "pent_vc");
    expect_v(S_VBL, 1, "pent_vbl"); expect_v(S_VS, 0, "pent_vs");
    expect_v(S_MODE, 0, "pent_mode_act");
    sync_chk();
    mon_h = 1'b0;

    // 34 short frames: interrupt, vertical flags, flash, then 1/4 duty and int_en off.
    do_reset(2'd2);
    for (int f = 0; f < 34; f++) begin
      b = f * 240;
      if (f < 33) begin push(K_INT, b + 44, 0); push(K_INT, b + 76, 1); end
      push(K_VS, b + 195, 1); push(K_VS, b + 215, 0);
      if (f > 0) push(K_VB, b + 175, 1);
      push(K_VB, b + 215, 0);
      push(K_FS, b + 240, 1);
    end
    push(K_FL, 3840, 1); push(K_FL, 7680, 0);
    run_to(60, 1);
    expect_v(S_NINT, 0, "int_low_mid");
    sync_chk();
    run_to(3840, 1);
    expect_v(S_FL, 1, "flash_after16");
    sync_chk();
    run_to(7680, 1);
    expect_v(S_FL, 0, "flash_after32"); expect_v(S_HC, 0, "f32_hc");
    expect_v(S_VC, 0, "f32_vc");
    sync_chk();
    run_to(7730, 4);
    int_en = 1'b0;
    run_to(8160, 4);
    expect_v(S_HC, 0, "f34_hc"); expect_v(S_VC, 0, "f34_vc");
    expect_v(S_NINT, 1, "int_disabled_high");
    sync_chk();
    int_en = 1'b1;

    // Profile change requested mid-frame takes effect only at the wrap.
    do_reset(2'd2);
    push(K_INT, 44, 0); push(K_INT, 76, 1);
    push(K_VS, 195, 1); push(K_VS, 215, 0); push(K_VB, 215, 0); push(K_FS, 240, 1);
    run_to(100, 1);
    mode = 2'd1;
    expect_v(S_MODE, 2, "mode_hold_mid");
    sync_chk();
    run_to(239, 1);
    expect_v(S_MODE, 2, "mode_hold_last"); expect_v(S_HC, 19, "mini_hmax");
    expect_v(S_VC, 11, "mini_vmax");
    sync_chk();
    run_to(240, 1);
    expect_v(S_MODE, 1, "mode_switched"); expect_v(S_HC, 0, "sw_hc0");
    sync_chk();
    run_to(265, 1);
    expect_v(S_HC, 25, "zx48_after_switch_hc"); expect_v(S_VC, 0, "zx48_after_switch_vc");
    sync_chk();

    // Reset while the interrupt pulse is active.
    do_reset(2'd2);
    push(K_INT, 44, 0);
    run_to(50, 1);
    expect_v(S_NINT, 0, "pre_rst_nint"); expect_v(S_HBL, 0, "pre_rst_hblank");
    sync_chk();
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    expect_v(S_NINT, 1, "rst_abort_nint"); expect_v(S_HC, 0, "rst2_hc");
    expect_v(S_VC, 0, "rst2_vc");          expect_v(S_HBL, 1, "rst2_hblank");
    expect_v(S_VBL, 1, "rst2_vblank");     expect_v(S_FS, 0, "rst2_fs");
    expect_v(S_MODE, 2, "rst2_mode_act");
    sync_chk();
    push(K_INT, 44, 0); push(K_INT, 76, 1);
    run_to(80, 1);
    expect_v(S_NINT, 1, "post_rst_int_done");
    sync_chk();

    done = 1'b1;
  end

endmodule
